debug_trace_buf: RTL and testbench
==================================

DEBUG_TRACE_BUF -- requirements
Module: debug_trace_buf

Interface
REQ-001 Parameter NUM_CH, default 5, number of CDB channels monitored (1..8).
REQ-002 Parameter DEPTH, default 16, trace entries; power of two, 4..256.
REQ-003 Parameter TAG_W, default 3, ROB tag width.
REQ-004 Parameter DATA_W, default 32, CDB data width.
REQ-005 Derived: CH_W = max(1, clog2(NUM_CH)); CNT_W = clog2(DEPTH)+1; ENTRY_W = 16+CH_W+TAG_W+DATA_W.
REQ-006 Clocking: one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 arm  in  1  single-cycle start request.
REQ-010 mode  in  2  0=wrap, 1=stop-on-full, 2=trigger; 3 is treated as 0.
REQ-011 stop  in  1  forces freeze.
REQ-012 trig_tag  in  TAG_W  trigger ROB tag (mode 2).
REQ-013 post_count  in  CNT_W  entries to capture after the trigger entry.
REQ-014 flush  in  1  ROB flush in progress; suppresses capture.
REQ-015 cdb_valid  in  NUM_CH  per-channel broadcast valid.
REQ-016 cdb_tag  in  NUM_CH*TAG_W  channel i tag at bits [i*TAG_W +: TAG_W].
REQ-017 cdb_data  in  NUM_CH*DATA_W  channel i data at bits [i*DATA_W +: DATA_W].
REQ-018 rd_ready  in  1  consumer accepts rd_entry.
REQ-019 rd_valid  out  1  rd_entry holds the oldest entry.
REQ-020 rd_entry  out  ENTRY_W  {stamp[15:0], ch, tag, data}, MSB first.
REQ-021 state  out  3  IDLE=0, RUN=1, WAIT_TRIG=2, POST=3, FROZEN=4.
REQ-022 count  out  CNT_W  entries currently held.
REQ-023 drop_cnt  out  16  saturating count of lost broadcasts.

Function
REQ-024 A 16-bit free-running stamp counter increments every cycle and wraps 0xFFFF->0.
REQ-025 Capture cycle: state is RUN, WAIT_TRIG or POST, flush=0, and any cdb_valid bit is set.
REQ-026 In a capture cycle, exactly one entry is written: the lowest-indexed valid channel, with the current stamp value.
REQ-027 In a capture cycle, drop_cnt increases by popcount(cdb_valid)-1 and saturates at 0xFFFF.
REQ-028 Entries are stored in a circular buffer with write and read pointers wrapping modulo DEPTH.
REQ-029 When a write occurs with count=DEPTH in RUN (mode 0) or WAIT_TRIG, the oldest entry is overwritten; the read pointer advances and count stays DEPTH; this is not a drop.
REQ-030 IDLE plus arm: mode is latched; mode 0/1 -> RUN, mode 2 -> WAIT_TRIG; buffer, read/write pointers, count and drop_cnt are cleared in the same edge.
REQ-031 arm outside IDLE is ignored.
REQ-032 RUN with latched mode 1: a write that makes count=DEPTH moves to FROZEN on the same edge.
REQ-033 WAIT_TRIG: the captured entry's tag equal to trig_tag means the trigger fires.
REQ-034 On a trigger, the trigger entry is written and the post counter loads post_count.
REQ-035 On a trigger with post_count=0 -> FROZEN; otherwise -> POST.
REQ-036 POST: each write decrements the post counter; the write that reaches 0 moves to FROZEN.
REQ-037 A write in POST with count=DEPTH overwrites the oldest entry.
REQ-038 stop=1 in RUN, WAIT_TRIG or POST -> FROZEN; a broadcast in that cycle is still captured.
REQ-039 stop has priority over the trigger and full transitions.
REQ-040 FROZEN: no capture, rd_valid=(count!=0), and rd_entry is driven combinationally from the read pointer.
REQ-041 FROZEN with rd_valid and rd_ready: pop one entry (read pointer +1, count -1).
REQ-042 The pop of the last entry moves to IDLE on the same edge.
REQ-043 FROZEN with count=0 -> IDLE on the next edge.
REQ-044 rd_valid=0 in all states other than FROZEN; rd_ready is ignored there.
REQ-045 flush=1 suppresses capture and drop counting; state transitions caused by stop still apply.

Reset
REQ-046 rst asserted: state=IDLE, pointers=0, count=0, drop_cnt=0, stamp=0, post counter=0, latched mode=0, rd_valid=0.
REQ-047 Reset mid-capture or mid-readout discards all entries; buffer RAM contents need not be cleared.

Verification
REQ-048 Mode 1, DEPTH=16, one channel valid for 20 cycles -> FROZEN after 16th write; count=16; reads return stamps in ascending order; then IDLE.
REQ-049 Mode 0, DEPTH=16, 20 single writes, then stop -> count=16; first read is write #5.
REQ-050 cdb_valid=5'b10110 for 3 cycles in RUN -> three ch=1 entries; drop_cnt=6.
REQ-051 Mode 2, trig_tag=3, post_count=2, tag 3 arrives on channel 2 -> FROZEN after 2 further writes; trigger entry is the third-newest.
REQ-052 flush=1 with all channels valid -> count and drop_cnt unchanged.
REQ-053 rst asserted during POST with count=9 -> IDLE, count=0, rd_valid=0 immediately (asynchronous).

Source files
------------

// File: rtl/debug_trace_buf.sv
// Debug trace buffer: snoops the CDB channels into a circular trace RAM with wrap,
// stop-on-full and tag-triggered capture modes, then drains it through a valid/ready port.
module debug_trace_buf #(
  parameter int NUM_CH = 5,
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W   = $clog2(DEPTH) + 1,
  localparam int ENTRY_W = 16 + CH_W + TAG_W + DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic [1:0]               mode,
  input  logic                     stop,
  input  logic [TAG_W-1:0]         trig_tag,
  input  logic [CNT_W-1:0]         post_count,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        cdb_valid,
  input  logic [NUM_CH*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CH*DATA_W-1:0] cdb_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [ENTRY_W-1:0]       rd_entry,
  output logic [2:0]               state,
  output logic [CNT_W-1:0]         count,
  output logic [15:0]              drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_POST   = 3'd3,
    ST_FROZEN = 3'd4
  } state_t;

  state_t             state_r;
  logic [1:0]         mode_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   post_r;
  logic [15:0]        drop_r;
  logic [15:0]        stamp_r;
  logic [ENTRY_W-1:0] mem_r [DEPTH];

  logic               hit_s;
  logic               cap_s;
  logic [CH_W-1:0]    sel_ch_s;
  logic [TAG_W-1:0]   sel_tag_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic [3:0]         pop_s;
  logic [16:0]        drop_sum_s;
  logic [15:0]        drop_next_s;
  logic               full_s;

  // Lowest-indexed valid channel wins; the rest are counted as drops.
  always_comb begin
    hit_s      = 1'b0;
    sel_ch_s   = '0;
    sel_tag_s  = '0;
    sel_data_s = '0;
    pop_s      = 4'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      pop_s = pop_s + 4'(cdb_valid[i]);
      if (cdb_valid[i]) begin
        hit_s      = 1'b1;
        sel_ch_s   = CH_W'(i);
        sel_tag_s  = cdb_tag[i*TAG_W +: TAG_W];
        sel_data_s = cdb_data[i*DATA_W +: DATA_W];
      end else begin
        hit_s      = hit_s;
      end
    end
  end

  // Capture qualification and saturating drop arithmetic.
  always_comb begin
    case (state_r)
      ST_RUN, ST_WAIT, ST_POST: cap_s = hit_s & ~flush;
      default:                  cap_s = 1'b0;
    endcase
    full_s     = (count_r == CNT_W'(DEPTH));
    drop_sum_s = {1'b0, drop_r} + 17'(pop_s) - 17'd1;
    if (drop_sum_s[16]) begin
      drop_next_s = 16'hFFFF;
    end else begin
      drop_next_s = drop_sum_s[15:0];
    end
  end

  // Control state, pointers and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      mode_r   <= 2'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      post_r   <= '0;
      drop_r   <= 16'd0;
      stamp_r  <= 16'd0;
    end else begin
      stamp_r <= stamp_r + 16'd1;
      if (cap_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        drop_r   <= drop_next_s;
        if (full_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end else begin
          count_r  <= count_r + CNT_W'(1);
        end
      end
      case (state_r)
        ST_IDLE: begin
          if (arm) begin
            mode_r   <= (mode == 2'd3) ? 2'd0 : mode;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            drop_r   <= 16'd0;
            state_r  <= (mode == 2'd2) ? ST_WAIT : ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_r <= ST_FROZEN;
          end else if (cap_s && mode_r == 2'd1 && count_r == CNT_W'(DEPTH - 1)) begin
            state_r <= ST_FROZEN;
          end
        end
        ST_WAIT: begin
          if (stop) begin
            state_r <= ST_FROZEN;
          end else if (cap_s && sel_tag_s == trig_tag) begin
            post_r  <= post_count;
            state_r <= (post_count == '0) ? ST_FROZEN : ST_POST;
          end
        end
        ST_POST: begin
          if (stop) begin
            state_r <= ST_FROZEN;
          end else if (cap_s) begin
            post_r <= post_r - CNT_W'(1);
            if (post_r == CNT_W'(1)) begin
              state_r <= ST_FROZEN;
            end
          end
        end
        ST_FROZEN: begin
          if (count_r == '0) begin
            state_r <= ST_IDLE;
          end else if (rd_ready) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            count_r  <= count_r - CNT_W'(1);
            if (count_r == CNT_W'(1)) begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Trace RAM write port; contents are meaningless outside [rd_ptr, rd_ptr+count).
  always_ff @(posedge clk) begin
    if (cap_s) begin
      mem_r[wr_ptr_r] <= {stamp_r, sel_ch_s, sel_tag_s, sel_data_s};
    end
  end

  assign rd_entry = mem_r[rd_ptr_r];
  assign rd_valid = (state_r == ST_FROZEN) && (count_r != '0);
  assign state    = state_r;
  assign count    = count_r;
  assign drop_cnt = drop_r;

endmodule

// File: tb/tb_debug_trace_buf.sv
// Scoreboard bench for debug_trace_buf: a queue-based trace model predicts state,
// occupancy, drops and the exact readout order of captured entries.
module tb_debug_trace_buf;
  localparam int NUM_CH  = 5;
  localparam int DEPTH   = 16;
  localparam int TAG_W   = 3;
  localparam int DATA_W  = 32;
  localparam int CH_W    = 3;
  localparam int CNT_W   = 5;
  localparam int ENTRY_W = 16 + CH_W + TAG_W + DATA_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     arm;
  logic [1:0]               mode;
  logic                     stop;
  logic [TAG_W-1:0]         trig_tag;
  logic [CNT_W-1:0]         post_count;
  logic                     flush;
  logic [NUM_CH-1:0]        cdb_valid;
  logic [NUM_CH*TAG_W-1:0]  cdb_tag;
  logic [NUM_CH*DATA_W-1:0] cdb_data;
  logic                     rd_ready;
  logic                     rd_valid;
  logic [ENTRY_W-1:0]       rd_entry;
  logic [2:0]               state;
  logic [CNT_W-1:0]         count;
  logic [15:0]              drop_cnt;

  debug_trace_buf #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .arm(arm), .mode(mode), .stop(stop), .trig_tag(trig_tag),
    .post_count(post_count), .flush(flush), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_entry(rd_entry),
    .state(state), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the trace is simply a queue of entries, oldest first.
  logic [ENTRY_W-1:0] mq[$];
  logic [ENTRY_W-1:0] exp_q[$];
  int          m_st;
  int          m_mode;
  int          m_post;
  int          m_drop;
  logic [15:0] m_stamp;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted readout must match the next expected entry.
  logic [ENTRY_W-1:0] mon_e;
  always @(negedge clk) begin
    if (rst === 1'b0 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual=%0h expected=none t=%0t", rd_entry, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_entry", 64'(rd_entry), 64'(mon_e));
      end
    end
  end

  task automatic model_step();
    bit                 cap;
    int                 ch;
    logic [TAG_W-1:0]   tg;
    cap = (m_st >= 1 && m_st <= 3) && !flush && (cdb_valid != '0);
    ch  = 0;
    tg  = '0;
    if (cap) begin
      while (!cdb_valid[ch]) ch++;
      tg = cdb_tag[ch*TAG_W +: TAG_W];
      if (mq.size() == DEPTH) void'(mq.pop_front());
      mq.push_back({m_stamp, 3'(ch), tg, cdb_data[ch*DATA_W +: DATA_W]});
      m_drop = m_drop + $countones(cdb_valid) - 1;
      if (m_drop > 65535) m_drop = 65535;
    end
    case (m_st)
      0: if (arm) begin
        m_mode = (mode == 2'd3) ? 0 : int'(mode);
        mq.delete();
        m_drop = 0;
        m_st = (m_mode == 2) ? 2 : 1;
      end
      1, 2, 3: begin
        if (stop) m_st = 4;
        else if (m_st == 1) begin
          if (m_mode == 1 && cap && mq.size() == DEPTH) m_st = 4;
        end else if (m_st == 2) begin
          if (cap && tg == trig_tag) begin
            m_post = int'(post_count);
            m_st = (m_post == 0) ? 4 : 3;
          end
        end else if (cap) begin
          m_post--;
          if (m_post == 0) m_st = 4;
        end
      end
      default: begin
        if (mq.size() == 0) m_st = 0;
        else if (rd_ready) begin
          exp_q.push_back(mq.pop_front());
          if (mq.size() == 0) m_st = 0;
        end
      end
    endcase
    m_stamp++;
  endtask

  task automatic step();
    check("state", 64'(state), 64'(m_st));
    check("count", 64'(count), 64'(mq.size()));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("rd_valid", 64'(rd_valid), 64'(m_st == 4 && mq.size() != 0));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_bus();
    for (int i = 0; i < NUM_CH; i++) cdb_data[i*DATA_W +: DATA_W] = $urandom;
    cdb_tag = NUM_CH*TAG_W'($urandom);
  endtask

  task automatic idle_in();
    arm = 1'b0; stop = 1'b0; flush = 1'b0; cdb_valid = '0; rd_ready = 1'b0;
    rand_bus();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    mq.delete(); exp_q.delete();
    m_st = 0; m_mode = 0; m_post = 0; m_drop = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_stamp = 16'd0;
  endtask

  task automatic do_arm(input logic [1:0] md);
    idle_in(); arm = 1'b1; mode = md; step(); arm = 1'b0;
  endtask

  task automatic drain();
    idle_in(); rd_ready = 1'b1;
    for (int k = 0; k < 3 * DEPTH && m_st != 0; k++) step();
    idle_in(); step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("idle_after_drain", 64'(state), 64'd0);
  endtask

  task automatic single_write(input int ch, input logic [TAG_W-1:0] tg);
    idle_in();
    cdb_valid = NUM_CH'(1) << ch;
    cdb_tag[ch*TAG_W +: TAG_W] = tg;
    step();
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; trig_tag = '0; post_count = '0;
    idle_in();
    do_reset();

    // Stop-on-full: freeze after the 16th write, ascending stamps on readout.
    do_arm(2'd1);
    for (int i = 0; i < 20; i++) single_write(0, 3'(i));
    check("mode1_frozen", 64'(state), 64'd4);
    check("mode1_count", 64'(count), 64'd16);
    drain();

    // Wrap: 20 writes then stop; readout starts with write #5.
    do_arm(2'd0);
    for (int i = 0; i < 20; i++) single_write(1, 3'(i));
    idle_in(); stop = 1'b1; step();
    check("wrap_count", 64'(count), 64'd16);
    drain();

    // Multi-channel: lowest index wins, the rest are drops.
    do_arm(2'd0);
    for (int i = 0; i < 3; i++) begin idle_in(); cdb_valid = 5'b10110; step(); end
    check("drop_6", 64'(drop_cnt), 64'd6);
    idle_in(); stop = 1'b1; step();
    drain();

    // Trigger on tag 3 via channel 2 with two post-trigger entries.
    trig_tag = 3'd3; post_count = 5'd2;
    do_arm(2'd2);
    for (int i = 0; i < 4; i++) single_write(0, 3'd1);
    idle_in(); cdb_valid = 5'b00100; cdb_tag[2*TAG_W +: TAG_W] = 3'd3; step();
    check("trig_post", 64'(state), 64'd3);
    single_write(3, 3'd0);
    single_write(4, 3'd3);
    check("trig_frozen", 64'(state), 64'd4);
    drain();

    // Flush suppresses capture and drop counting.
    do_arm(2'd3);
    for (int i = 0; i < 3; i++) single_write(0, 3'd2);
    for (int i = 0; i < 3; i++) begin idle_in(); flush = 1'b1; cdb_valid = 5'b11111; step(); end
    check("flush_count", 64'(count), 64'd3);
    check("flush_drop", 64'(drop_cnt), 64'd0);
    idle_in(); stop = 1'b1; flush = 1'b1; step();
    drain();

    // Asynchronous reset in POST with nine entries held.
    trig_tag = 3'd5; post_count = 5'd20;
    do_arm(2'd2);
    for (int i = 0; i < 4; i++) single_write(0, 3'd0);
    single_write(1, 3'd5);
    for (int i = 0; i < 4; i++) single_write(0, 3'd0);
    check("pre_rst_state", 64'(state), 64'd3);
    check("pre_rst_count", 64'(count), 64'd9);
    do_reset();

    // Randomized sessions with all controls exercised.
    for (int s = 0; s < 30; s++) begin
      trig_tag = 3'($urandom_range(0, 3));
      post_count = 5'($urandom_range(0, 6));
      do_arm(2'($urandom));
      for (int c = 0; c < 60; c++) begin
        idle_in();
        cdb_valid = ($urandom_range(0, 3) == 0) ? '0 : NUM_CH'($urandom);
        for (int i = 0; i < NUM_CH; i++) cdb_tag[i*TAG_W +: TAG_W] = 3'($urandom_range(0, 3));
        flush    = ($urandom_range(0, 7) == 0);
        stop     = ($urandom_range(0, 39) == 0);
        arm      = ($urandom_range(0, 9) == 0);
        mode     = 2'($urandom);
        rd_ready = $urandom_range(0, 1) == 1;
        step();
      end
      idle_in(); stop = 1'b1; step();
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
